// File: rtl/glitch_sequencer.sv
// Trigger-synchronous glitch sequencer: plays up to 2**ADDR_W delay/width pulses from a table.
// Define GLITCH_TRIG_SYNC_EN to pass trigger_i through a 2-flop synchroniser.
module glitch_sequencer #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned WIDTH_W = 12,
  parameter int unsigned ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [ADDR_W:0]    cfg_count,
  input  logic [CNT_W-1:0]   reset_length,
  input  logic [1:0]         reset_mode,
  input  logic [1:0]         trig_edge,
  input  logic               auto_rearm,
  input  logic               start_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic               abort_i,
  input  logic               trigger_i,
  output logic               pulse_o,
  output logic               target_reset_o,
  output logic               busy_o,
  output logic               armed_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  entry_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StReset, StDelay, StPulse} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  entry_q, entry_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [CNT_W-1:0]   rlen_q, rlen_d;
  logic [1:0]         mode_q, mode_d;
  logic               armed_q, armed_d;
  logic               done_q, done_d;
  logic               empty_q, empty_d;
  logic               by_trig_q, by_trig_d;
  logic               trig_prev_q, trig_prev_d;
  logic [CNT_W-1:0]   delay_q [DEPTH];
  logic [CNT_W-1:0]   delay_d [DEPTH];
  logic [WIDTH_W-1:0] width_q [DEPTH];
  logic [WIDTH_W-1:0] width_d [DEPTH];

  logic               trig_s, edge_ok, trig_hit;
  logic [ADDR_W:0]    count_in, scan_cnt, scan_from;
  logic               found, nxt_delay;
  logic [ADDR_W-1:0]  nxt_idx;
  logic [CNT_W-1:0]   cur_d, cur_w_ext;
  logic               launch, advance, finish;

`ifdef GLITCH_TRIG_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], trigger_i};
  assign trig_s = sync_q[1];
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end
`else
  assign trig_s = trigger_i;
`endif

  always_comb begin
    case (trig_edge)
      2'b00:   edge_ok = trig_s;
      2'b01:   edge_ok = trig_s & ~trig_prev_q;
      2'b10:   edge_ok = ~trig_s & trig_prev_q;
      default: edge_ok = trig_s ^ trig_prev_q;
    endcase
  end

  assign trig_hit  = armed_q && (state_q == StIdle) && edge_ok;
  assign count_in  = (cfg_count > DepthCnt) ? DepthCnt : cfg_count;
  assign cur_d     = delay_q[entry_q];
  assign cur_w_ext = CNT_W'(width_q[entry_q]);

  // Find the next entry at or after scan_from that consumes at least one cycle.
  always_comb begin
    scan_cnt  = (state_q == StIdle) ? count_in : count_q;
    scan_from = (state_q == StDelay || state_q == StPulse) ?
                ({1'b0, entry_q} + (ADDR_W + 1)'(1)) : '0;
    found     = 1'b0;
    nxt_idx   = '0;
    nxt_delay = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if ((ADDR_W + 1)'(k) >= scan_from && (ADDR_W + 1)'(k) < scan_cnt &&
          (delay_q[k] != '0 || width_q[k] != '0)) begin
        found     = 1'b1;
        nxt_idx   = ADDR_W'(k);
        nxt_delay = (delay_q[k] != '0);
      end
    end
  end

  always_comb begin
    delay_d = delay_q;
    width_d = width_q;
    if (cfg_we && state_q == StIdle) begin
      delay_d[cfg_addr] = cfg_delay;
      width_d[cfg_addr] = cfg_width;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    entry_d     = entry_q;
    count_d     = count_q;
    rlen_d      = rlen_q;
    mode_d      = mode_q;
    armed_d     = armed_q;
    done_d      = 1'b0;
    empty_d     = empty_q;
    by_trig_d   = by_trig_q;
    trig_prev_d = trig_s;
    launch      = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d   = count_in;
          rlen_d    = reset_length;
          mode_d    = reset_mode;
          by_trig_d = 1'b0;
          if (reset_length != '0) begin
            state_d = StReset;
            cnt_d   = '0;
          end else begin
            launch = 1'b1;
          end
        end else if (trig_hit) begin
          count_d   = count_in;
          by_trig_d = 1'b1;
          armed_d   = 1'b0;
          launch    = 1'b1;
        end
      end
      StReset: begin
        if (cnt_q == rlen_q - One) begin
          if (mode_q == 2'b01) begin
            launch = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (mode_q == 2'b10) armed_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StDelay: begin
        if (empty_q) begin
          finish = 1'b1;
        end else if (cnt_q == cur_d - One) begin
          if (cur_w_ext != '0) begin
            state_d = StPulse;
            cnt_d   = '0;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StPulse: begin
        if (cnt_q == cur_w_ext - One) advance = 1'b1;
        else                          cnt_d   = cnt_q + One;
      end
    endcase

    // An empty sequence still spends one cycle in DELAY so done_o lands on the following edge.
    if (launch || advance) begin
      if (found) begin
        state_d = nxt_delay ? StDelay : StPulse;
        entry_d = nxt_idx;
        cnt_d   = '0;
        empty_d = 1'b0;
      end else if (launch) begin
        state_d = StDelay;
        entry_d = '0;
        cnt_d   = '0;
        empty_d = 1'b1;
      end else begin
        finish = 1'b1;
      end
    end

    if (finish) begin
      state_d = StIdle;
      done_d  = 1'b1;
      entry_d = '0;
      empty_d = 1'b0;
      if (by_trig_q && auto_rearm) armed_d = 1'b1;
    end

    if (arm_i)    armed_d = 1'b1;
    if (disarm_i) armed_d = 1'b0;

    if (abort_i) begin
      state_d = StIdle;
      armed_d = 1'b0;
      done_d  = 1'b0;
      entry_d = '0;
      cnt_d   = '0;
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      entry_q     <= '0;
      count_q     <= '0;
      rlen_q      <= '0;
      mode_q      <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 1'b0;
      by_trig_q   <= 1'b0;
      trig_prev_q <= 1'b0;
      delay_q     <= '{default: '0};
      width_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      rlen_q      <= rlen_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
      by_trig_q   <= by_trig_d;
      trig_prev_q <= trig_prev_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
    end
  end

  assign pulse_o        = (state_q == StPulse);
  assign target_reset_o = (state_q == StReset);
  assign busy_o         = (state_q != StIdle);
  assign armed_o        = armed_q;
  assign done_o         = done_q;
  assign entry_o        = entry_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: directed scenarios plus randomized tables checked against a
// cycle-timeline model built from the delay/width arithmetic.
module tb_glitch_sequencer;
  localparam int CNT_W   = 24;
  localparam int WIDTH_W = 12;
  localparam int ADDR_W  = 3;
  localparam int DEPTH   = 8;
  localparam int MaxT    = 256;
`ifdef GLITCH_TRIG_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [CNT_W-1:0]   cfg_delay;
  logic [WIDTH_W-1:0] cfg_width;
  logic [ADDR_W:0]    cfg_count;
  logic [CNT_W-1:0]   reset_length;
  logic [1:0]         reset_mode;
  logic [1:0]         trig_edge;
  logic               auto_rearm, start_i, arm_i, disarm_i, abort_i, trigger_i;
  logic               pulse_o, target_reset_o, busy_o, armed_o, done_o;
  logic [ADDR_W-1:0]  entry_o;

  int checks = 0;
  int errors = 0;

  int m_d [DEPTH];
  int m_w [DEPTH];
  bit exp_pulse [MaxT];
  bit exp_rst   [MaxT];
  bit exp_done  [MaxT];
  bit exp_busy  [MaxT];
  int chk_len;

  glitch_sequencer #(.CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
    .cfg_width(cfg_width), .cfg_count(cfg_count), .reset_length(reset_length),
    .reset_mode(reset_mode), .trig_edge(trig_edge), .auto_rearm(auto_rearm),
    .start_i(start_i), .arm_i(arm_i), .disarm_i(disarm_i), .abort_i(abort_i),
    .trigger_i(trigger_i), .pulse_o(pulse_o), .target_reset_o(target_reset_o),
    .busy_o(busy_o), .armed_o(armed_o), .done_o(done_o), .entry_o(entry_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d, input int w);
    cfg_we    = 1'b1;
    cfg_addr  = ADDR_W'(a);
    cfg_delay = CNT_W'(d);
    cfg_width = WIDTH_W'(w);
    step();
    cfg_we = 1'b0;
    m_d[a] = d;
    m_w[a] = w;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm_i = 1'b1;
    step();
    disarm_i = 1'b0;
  endtask

  // Timeline index t = value seen just after edge E+t, E being the edge that leaves IDLE.
  task automatic build_model(input int len, input int mode, input int cnt_raw);
    int n, c, done_t;
    for (int t = 0; t < MaxT; t++) begin
      exp_pulse[t] = 0; exp_rst[t] = 0; exp_done[t] = 0; exp_busy[t] = 0;
    end
    n = (cnt_raw > DEPTH) ? DEPTH : cnt_raw;
    for (int t = 0; t < len; t++) exp_rst[t] = 1;
    if (len != 0 && mode != 1) begin
      done_t = len;
    end else begin
      c = len;
      for (int i = 0; i < n; i++) begin
        c += m_d[i];
        for (int k = 0; k < m_w[i]; k++) exp_pulse[c + k] = 1;
        c += m_w[i];
      end
      // A sequence that consumes no cycles ends on the edge after it starts.
      done_t = (c == len) ? len + 1 : c;
    end
    exp_done[done_t] = 1;
    for (int t = 0; t < done_t; t++) exp_busy[t] = 1;
    chk_len = done_t + 3;
  endtask

  task automatic check_run(input string tag);
    for (int t = 0; t < chk_len; t++) begin
      @(negedge clk);
      chk({tag, ".pulse"}, t, 32'(pulse_o), 32'(exp_pulse[t]));
      chk({tag, ".treset"}, t, 32'(target_reset_o), 32'(exp_rst[t]));
      chk({tag, ".done"}, t, 32'(done_o), 32'(exp_done[t]));
      chk({tag, ".busy"}, t, 32'(busy_o), 32'(exp_busy[t]));
    end
    step();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".pulse"}, 0, 32'(pulse_o), 32'd0);
    chk({tag, ".treset"}, 0, 32'(target_reset_o), 32'd0);
    chk({tag, ".busy"}, 0, 32'(busy_o), 32'd0);
    chk({tag, ".armed"}, 0, 32'(armed_o), 32'd0);
    chk({tag, ".done"}, 0, 32'(done_o), 32'd0);
    chk({tag, ".entry"}, 0, 32'(entry_o), 32'd0);
  endtask

  initial begin
    int cnt, len, mode, n, sum;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0; cfg_width = '0;
    cfg_count = '0; reset_length = '0; reset_mode = '0; trig_edge = 2'b01;
    auto_rearm = 1'b0; start_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; abort_i = 1'b0;
    trigger_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_d[i] = 0; m_w[i] = 0; end
    repeat (3) step();
    check_quiet("reset");
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    // Two-entry sequence, software start, no target reset.
    write_entry(0, 5, 3);
    write_entry(1, 2, 4);
    cfg_count = 3'd2; reset_length = '0; reset_mode = 2'b00;
    build_model(0, 0, 2);
    pulse_start();
    check_run("two_entry");

    // Target reset then an immediate one-cycle pulse.
    write_entry(0, 0, 1);
    cfg_count = 3'd1; reset_length = 10; reset_mode = 2'b01;
    build_model(10, 1, 1);
    pulse_start();
    check_run("reset_run");

    // Reset then arm.
    reset_length = 4; reset_mode = 2'b10;
    build_model(4, 2, 1);
    pulse_start();
    check_run("reset_arm");
    chk("reset_arm.armed", 0, 32'(armed_o), 32'd1);
    arm_i = 1'b1; disarm_i = 1'b1;
    step();
    arm_i = 1'b0; disarm_i = 1'b0;
    chk("disarm_wins", 0, 32'(armed_o), 32'd0);

    // Empty sequence.
    cfg_count = '0; reset_length = '0; reset_mode = 2'b00;
    build_model(0, 0, 0);
    pulse_start();
    check_run("count0");

    // Rising-edge trigger with auto re-arm and trigger held high.
    write_entry(0, 3, 2);
    cfg_count = 3'd1; trig_edge = 2'b01; auto_rearm = 1'b1;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("arm", 0, 32'(armed_o), 32'd1);
    build_model(0, 0, 1);
    trigger_i = 1'b1;
    step();
    repeat (SyncLat) step();
    check_run("trig1");
    chk("trig1.rearmed", 0, 32'(armed_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_high.busy", i, 32'(busy_o), 32'd0);
    end
    trigger_i = 1'b0;
    repeat (4) step();
    chk("fall_ignored.busy", 0, 32'(busy_o), 32'd0);
    chk("fall_ignored.armed", 0, 32'(armed_o), 32'd1);
    trigger_i = 1'b1;
    step();
    repeat (SyncLat) step();
    check_run("trig2");

    // Both-edge trigger, long delay, abort mid-delay.
    pulse_disarm();
    trig_edge = 2'b11; auto_rearm = 1'b0;
    write_entry(0, 100, 3);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    repeat (3) step();
    trigger_i = 1'b0;
    step();
    repeat (SyncLat) step();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      chk("abort.pulse", t, 32'(pulse_o), 32'd0);
      chk("abort.done", t, 32'(done_o), 32'd0);
      chk("abort.busy", t, 32'(busy_o), (t < 50) ? 32'd1 : 32'd0);
      chk("abort.armed", t, 32'(armed_o), 32'd0);
      if (t == 49) abort_i = 1'b1;
      if (t == 50) abort_i = 1'b0;
    end
    step();

    // Table write and arm while busy: write ignored, arm accepted.
    trig_edge = 2'b01;
    write_entry(0, 3, 2);
    cfg_count = 3'd1; reset_length = '0;
    pulse_start();
    cfg_we = 1'b1; cfg_addr = '0; cfg_delay = CNT_W'(1); cfg_width = WIDTH_W'(6);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    step();
    cfg_we = 1'b0;
    for (int i = 0; i < 200 && busy_o; i++) step();
    chk("busy_write.idle", 0, 32'(busy_o), 32'd0);
    chk("busy_arm.armed", 0, 32'(armed_o), 32'd1);
    pulse_disarm();
    build_model(0, 0, 1);
    pulse_start();
    check_run("busy_write");

    // Reset mid-sequence, then confirm the table came back cleared.
    write_entry(1, 4, 1);
    cfg_count = 3'd2;
    pulse_start();
    repeat (4) step();
    rst = 1'b1;
    step();
    check_quiet("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_d[i] = 0; m_w[i] = 0; end
    step();
    write_entry(0, 2, 2);
    cfg_count = 3'd2; reset_length = '0; reset_mode = 2'b00;
    build_model(0, 0, 2);
    pulse_start();
    check_run("cleared_table");

    // Randomized tables, counts (including over-range) and reset settings.
    for (int iter = 0; iter < 25; iter++) begin
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      cnt  = int'($urandom_range(0, 15));
      len  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      mode = int'($urandom_range(0, 3));
      n    = (cnt > DEPTH) ? DEPTH : cnt;
      sum  = 0;
      for (int i = 0; i < n; i++) sum += m_d[i] + m_w[i];
      if (n > 0 && sum == 0) write_entry(0, m_d[0], 1);
      cfg_count    = (ADDR_W + 1)'(cnt);
      reset_length = CNT_W'(len);
      reset_mode   = 2'(mode);
      build_model(len, mode, cnt);
      pulse_start();
      check_run("rnd");
      chk("rnd.armed", iter, 32'(armed_o), (len > 0 && mode == 2) ? 32'd1 : 32'd0);
      pulse_disarm();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
